micromult_core: RTL and testbench
=================================

Name: micromult_core

Overview:
- Sequential unsigned shift-and-add multiplier. It is the arithmetic stage directly downstream of the tt_um_micromult_njp pad wrapper.
- The wrapper feeds it operand A from ui_in and operand B from uio_in, plus a start strobe.
- The wrapper consumes the product, busy and done and presents them on uo_out / uio_out.
- One partial-product iteration per clock, which trades latency for area.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design enable from the wrapper; when low, all state holds.
- start  input  1  request to multiply a*b; sampled on a rising edge.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  last completed result; holds between operations.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, product=0; internal accumulator, shift registers and counter cleared.
- FSM states:
  - IDLE: waiting for start.
  - RUN: iterating.
- IDLE, with ena=1 and start=1 at edge E0:
  - Latch mcand={WIDTH'0,a}, mplr=b.
  - Clear acc (2*WIDTH bits) and cnt.
  - Go to RUN; busy=1 from E0.
- RUN, each edge with ena=1:
  - If mplr[0], acc <= acc + mcand (modulo 2^(2*WIDTH); cannot overflow for unsigned operands).
  - mcand <<= 1; mplr >>= 1; cnt++.
- Completion at edge E(WIDTH), i.e. the WIDTH-th RUN iteration:
  - product <= final acc, including that iteration's add.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: product is valid WIDTH cycles after the accepting edge (8 cycles at default).
- Operands are captured at E0 only; changes to a and b during RUN have no effect.
- start while busy: ignored; no restart and no queueing.
- start held high continuously: a new operation is accepted at E(WIDTH+1), the first IDLE edge. done pulses at E(WIDTH) and busy reasserts at E(WIDTH+1), so busy and done are never both high.
- ena=0: FSM, counters, acc, product, busy and done all hold their values. start is not accepted. A done pulse that is already high stays high until the next edge with ena=1, then clears.
- done clears on the next ena=1 edge after assertion, regardless of start.
- product changes only at completion or reset.
- Reset mid-RUN: operation aborted; outputs return to reset values; no done pulse.
- Zero operand: the full WIDTH cycles still elapse; there is no early termination.
- cnt width is clog2(WIDTH)+1; terminal count is WIDTH-1, checked before increment.

Test Plan:
- Reset, then a=13, b=11, start pulse -> busy high 8 cycles; done pulse 8 cycles after the accepting edge; product=143 (0x008F).
- a=255, b=255 -> product=65025 (0xFE01). Then a=0, b=200 -> product=0 after the full 8 cycles, with done pulse.
- Start accepted with a=3, b=5. While busy, drive a=200, b=200 and pulse start -> ignored; product=15; exactly one done pulse.
- start held high with a=7, b=9 -> done pulse with product=63, then busy reasserts on the next edge; results repeat every 9 cycles.
- Start a=100, b=100; after 4 cycles drop ena for 5 cycles -> busy held, no progress. Raise ena -> completes 4 cycles later with product=10000 (0x2710).
- Start a=50, b=60; after 3 cycles assert rst_n=0 asynchronously -> busy=0, done=0, product=0 immediately. After release, no done pulse appears and IDLE accepts a new start.

Source files
------------

// File: rtl/micromult_core.sv
// Sequential unsigned shift-and-add multiplier: one partial product per enabled clock,
// result published with a one-cycle done pulse after WIDTH iterations.
module micromult_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc, mcand, acc_add;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;
    logic               last;

    assign busy = (state == RUN);

    always_comb begin
        state_nxt = state;
        acc_add   = mplr[0] ? acc + mcand : acc;
        last      = (cnt == CW'(WIDTH - 1));
        if (ena) begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (last)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath; everything freezes while ena is low, including a pending done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_add;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        product <= acc_add;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_micromult_core.sv
// Self-checking bench for micromult_core: vector table, hand-written corner sequences
// and randomized operands checked against plain a*b arithmetic.
module tb_micromult_core;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   a_i = '0;
    logic [WIDTH-1:0]   b_i = '0;
    logic               busy, done;
    logic [2*WIDTH-1:0] product;

    int pass_cnt = 0;
    int total_cnt = 0;

    micromult_core #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .a(a_i), .b(b_i), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done with a bound; returns the number of edges taken.
    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    // Full operation; operands are scrambled during RUN to confirm capture at E0 only.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] exp, input string name);
        int n, drops;
        a_i = a; b_i = b; start = 1'b1;
        tick();
        check({name, "_busy_e0"}, busy, 1);
        start = 1'b0;
        n = 0; drops = 0;
        while (!done && n < 40) begin
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            tick();
            n++;
            if (!done && !busy) drops++;
        end
        check({name, "_latency"}, n, WIDTH);
        check({name, "_busy_drop"}, drops, 0);
        check({name, "_product"}, product, exp);
        check({name, "_busy_at_done"}, busy, 0);
        tick();
        check({name, "_done_1cyc"}, done, 0);
        check({name, "_product_hold"}, product, exp);
    endtask

    initial begin
        int n, pulses;
        logic [2*WIDTH-1:0] first;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd1,   8'd1,   16'd1};
        vecs[4] = '{8'd128, 8'd2,   16'd256};
        vecs[5] = '{8'd255, 8'd0,   16'd0};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Randomized operands against plain arithmetic
        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] ra, rb;
            int m;
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            m = int'(ra) * int'(rb);
            run_op(ra, rb, (2*WIDTH)'(m), $sformatf("rnd%0d", i));
        end

        // start while busy is ignored
        a_i = 8'd3; b_i = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_i = 8'd200; b_i = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                pulses++;
                check("ign_product", product, 15);
            end
            tick();
        end
        check("ign_pulses", pulses, 1);
        check("ign_idle", busy, 0);

        // start held high: back-to-back operations every WIDTH+1 cycles
        a_i = 8'd7; b_i = 8'd9; start = 1'b1;
        tick();
        wait_done(40, n);
        check("held_lat", n, WIDTH);
        for (int k = 0; k < 3; k++) begin
            check("held_product", product, 63);
            check("held_no_overlap", busy, 0);
            tick();
            check("held_busy_again", busy, 1);
            check("held_done_clr", done, 0);
            if (k == 2) start = 1'b0;
            wait_done(40, n);
            check("held_period", n + 1, WIDTH + 1);
        end
        tick();
        check("held_end_idle", busy, 0);

        // ena low mid-run freezes progress; a pending done also freezes
        a_i = 8'd100; b_i = 8'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) begin
                check("ena_busy_hold", busy, 1);
                check("ena_no_done", done, 0);
                check("ena_prod_hold", product, 63);
            end
        end
        ena = 1'b1;
        wait_done(40, n);
        check("ena_resume_lat", n, 4);
        check("ena_product", product, 10000);
        ena = 1'b0;
        tick();
        check("ena_done_held", done, 1);
        ena = 1'b1;
        tick();
        check("ena_done_clr", done, 0);

        // Asynchronous reset mid-run aborts without a done pulse
        a_i = 8'd50; b_i = 8'd60; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_product", product, 0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check("arst_no_done", pulses, 0);
        first = 16'd42;
        run_op(8'd6, 8'd7, first, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
